// File: rtl/mem_access_pkg.sv
// Shared op encodings, FSM states and byte-lane helpers for the MEM-stage memory initiator.
// Pure definitions: no logic, no latency, no flow control.
package mem_access_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FAULT   = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    // Big-endian byte 0 lives in bits 31:24, hence the inverted offset.
    function automatic logic [4:0] byte_shift(input logic [1:0] off, input logic big);
        return big ? {~off, 3'b000} : {off, 3'b000};
    endfunction

    function automatic logic [4:0] half_shift(input logic off_hi, input logic big);
        return big ? {~off_hi, 4'b0000} : {off_hi, 4'b0000};
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        return op < OP_SW;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            OP_LW, OP_SW:         mis = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis = off[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lane_formatter.sv
// Byte/halfword lane extract with sign/zero extension, and sub-word store merge.
// Purely combinational, no latency, no flow control.
module lane_formatter
    import mem_access_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] word_i,
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsh  = byte_shift(off_i, BIG_ENDIAN);
        hsh  = half_shift(off_i[1], BIG_ENDIAN);
        bsel = 8'(word_i >> bsh);
        hsel = 16'(word_i >> hsh);

        case (op_i)
            OP_LW:   load_o = word_i;
            OP_LH:   load_o = {{16{hsel[15]}}, hsel};
            OP_LHU:  load_o = {16'h0000, hsel};
            OP_LB:   load_o = {{24{bsel[7]}}, bsel};
            OP_LBU:  load_o = {24'h00_0000, bsel};
            default: load_o = 32'h0000_0000;
        endcase

        case (op_i)
            OP_SB:   merge_o = (word_i & ~(BYTE_MASK << bsh)) | ((wdata_i & BYTE_MASK) << bsh);
            OP_SH:   merge_o = (word_i & ~(HALF_MASK << hsh)) | ((wdata_i & HALF_MASK) << hsh);
            OP_SW:   merge_o = wdata_i;
            default: merge_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// One-at-a-time load/store initiator; loads and SB/SH take READ_LAT+1 cycles, SW and faults take 1.
// req_ready drops while a read is outstanding and is high again in the response cycle.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned READ_LAT   = 1,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    localparam int unsigned CW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     mem_a_q, mem_a_d;
    logic [31:0]     mem_wd_q, mem_wd_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic            misalign_in;
    logic            rd_done;
    logic [31:0]     fmt_load;
    logic [31:0]     fmt_merge;

    assign accept      = req_valid && req_ready;
    assign misalign_in = is_misaligned(req_op, req_addr[1:0]);
    assign rd_done     = (state_q == ST_RD_WAIT) && (cnt_q == CW'(1));

    lane_formatter #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_fmt (
        .word_i  (mem_RD),
        .op_i    (op_q),
        .off_i   (off_q),
        .wdata_i (wdata_q),
        .load_o  (fmt_load),
        .merge_o (fmt_merge)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Terminal states accept the next request directly so back-to-back ops leave no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RD_WAIT: begin
                if (rd_done) begin
                    state_d = is_load(op_q) ? ST_RESP : ST_WRITE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (misalign_in) begin
                        state_d = ST_FAULT;
                    end else if (req_op == OP_SW) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
        endcase
    end

    always_comb begin
        req_ready     = (state_q != ST_RD_WAIT);
        resp_valid    = (state_q == ST_FAULT) || (state_q == ST_WRITE) || (state_q == ST_RESP);
        resp_misalign = (state_q == ST_FAULT);
        resp_rdata    = (state_q == ST_RESP) ? rdata_q : 32'h0000_0000;
        mem_WE        = (state_q == ST_WRITE);
        mem_A         = mem_a_q;
        mem_WD        = mem_wd_q;
    end

    always_comb begin
        op_d     = op_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        if (accept) begin
            op_d    = req_op;
            off_d   = req_addr[1:0];
            wdata_d = req_wdata;
            cnt_d   = CW'(READ_LAT);
            // A faulting access never reaches memory, so the address bus keeps its old value.
            if (!misalign_in) begin
                mem_a_d = {req_addr[31:2], 2'b00};
                if (req_op == OP_SW) begin
                    mem_wd_d = req_wdata;
                end
            end
        end else if (state_q == ST_RD_WAIT) begin
            cnt_d = cnt_q - CW'(1);
            if (rd_done) begin
                if (is_load(op_q)) begin
                    rdata_d = fmt_load;
                end else begin
                    mem_wd_d = fmt_merge;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q     <= OP_LW;
            off_q    <= 2'b00;
            wdata_q  <= 32'h0000_0000;
            mem_a_q  <= 32'h0000_0000;
            mem_wd_q <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            cnt_q    <= '0;
        end else begin
            op_q     <= op_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed spec scenarios then random ops against a byte-level memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int unsigned RL  = 1;
    localparam bit          BIG = 1'b1;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    logic [31:0] bmem [256];
    logic        tb_wr;
    logic [7:0]  tb_idx;
    logic [31:0] tb_dat;

    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] last_a;
    logic [31:0] got_rdata;
    logic        got_mis;
    int          got_lat;

    mem_access_unit #(
        .READ_LAT   (RL),
        .BIG_ENDIAN (BIG)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .mem_A         (mem_A),
        .mem_WD        (mem_WD),
        .mem_WE        (mem_WE),
        .mem_RD        (mem_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Asynchronous-read memory: mem_RD follows mem_A, so any READ_LAT >= 1 sees valid data.
    assign mem_RD = bmem[mem_A[9:2]];

    always @(posedge CLK) begin
        if (mem_WE) bmem[mem_A[9:2]] <= mem_WD;
        else if (tb_wr) bmem[tb_idx] <= tb_dat;
    end

    always @(negedge CLK) begin
        if (mem_WE) we_cnt++;
        if (resp_valid) resp_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] dat);
        tb_idx = idx;
        tb_dat = dat;
        tb_wr  = 1'b1;
        @(posedge CLK);
        #1 tb_wr = 1'b0;
    endtask

    // Memory seen as four byte addresses per word, byte j at address offset j.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input int j);
        return BIG ? w[8*(3-j) +: 8] : w[8*j +: 8];
    endfunction

    function automatic logic ref_mis(input logic [2:0] op, input logic [1:0] off);
        if (op == OP_LW || op == OP_SW) return off != 2'd0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return off[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] w, input logic [1:0] off);
        int          o;
        logic [7:0]  b;
        logic [15:0] h;
        o = int'(off);
        case (op)
            OP_LW:  return w;
            OP_LB:  begin b = get_byte(w, o); return {{24{b[7]}}, b}; end
            OP_LBU: begin b = get_byte(w, o); return {24'd0, b}; end
            OP_LH, OP_LHU: begin
                h = BIG ? {get_byte(w, o), get_byte(w, o+1)} : {get_byte(w, o+1), get_byte(w, o)};
                return (op == OP_LH) ? {{16{h[15]}}, h} : {16'd0, h};
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] w,
                                              input logic [31:0] wd, input logic [1:0] off);
        logic [7:0]  b [4];
        logic [31:0] r;
        int          o;
        o = int'(off);
        if (op == OP_SW) return wd;
        for (int j = 0; j < 4; j++) b[j] = get_byte(w, j);
        if (op == OP_SB) begin
            b[o] = wd[7:0];
        end else if (op == OP_SH) begin
            if (BIG) begin b[o] = wd[15:8]; b[o+1] = wd[7:0]; end
            else     begin b[o] = wd[7:0];  b[o+1] = wd[15:8]; end
        end
        r = 32'd0;
        for (int j = 0; j < 4; j++) begin
            if (BIG) r[8*(3-j) +: 8] = b[j];
            else     r[8*j +: 8]     = b[j];
        end
        return r;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] old_w, exp_w, exp_rd, exp_a;
        logic        mis;
        int          exp_lat, exp_we, we0, n;
        old_w   = bmem[addr[9:2]];
        mis     = ref_mis(op, addr[1:0]);
        exp_rd  = (mis || op >= OP_SW) ? 32'd0 : ref_load(op, old_w, addr[1:0]);
        exp_w   = (mis || op < OP_SW) ? old_w : ref_store(op, old_w, wd, addr[1:0]);
        exp_lat = (mis || op == OP_SW) ? 1 : int'(RL) + 1;
        exp_we  = (!mis && op >= OP_SW) ? 1 : 0;
        exp_a   = mis ? last_a : {addr[31:2], 2'b00};

        @(negedge CLK);
        we0       = we_cnt;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge CLK); n++; end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge CLK);
        #1 req_valid = 1'b0;

        got_lat = 0;
        do begin
            @(negedge CLK);
            got_lat++;
        end while (!resp_valid && got_lat < 20);
        got_rdata = resp_rdata;
        got_mis   = resp_misalign;
        chk("latency", 32'(got_lat), 32'(exp_lat));
        chk("rdata", got_rdata, exp_rd);
        chk("misalign", {31'd0, got_mis}, {31'd0, mis});
        chk("mem_A", mem_A, exp_a);

        @(negedge CLK);
        chk("we_pulses", 32'(we_cnt - we0), 32'(exp_we));
        chk("mem_word", bmem[addr[9:2]], exp_w);
        last_a = exp_a;
    endtask

    initial begin
        int r0, w0;
        RST = 1'b0; req_valid = 1'b0; req_op = OP_LW; req_addr = 32'd0; req_wdata = 32'd0;
        tb_wr = 1'b0; tb_idx = 8'd0; tb_dat = 32'd0; last_a = 32'd0;
        got_rdata = 32'd0; got_mis = 1'b0; got_lat = 0;
        #1 RST = 1'b1;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_misalign", {31'd0, resp_misalign}, 32'd0);
        chk("rst_mem_A", mem_A, 32'd0);
        chk("rst_mem_WD", mem_WD, 32'd0);
        chk("rst_mem_WE", {31'd0, mem_WE}, 32'd0);

        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
        poke(8'h04, 32'h8899_AABB);
        poke(8'h08, 32'h1122_3344);
        @(negedge CLK) RST = 1'b0;

        run_op(OP_LW, 32'h0040_0010, 32'd0);
        chk("lw_value", got_rdata, 32'h8899_AABB);
        chk("lw_latency", 32'(got_lat), 32'd2);
        chk("lw_mem_A", mem_A, 32'h0040_0010);
        run_op(OP_LB, 32'h0040_0012, 32'd0);
        chk("lb_value", got_rdata, 32'hFFFF_FFAA);
        run_op(OP_LBU, 32'h0040_0012, 32'd0);
        chk("lbu_value", got_rdata, 32'h0000_00AA);
        run_op(OP_LH, 32'h0040_0010, 32'd0);
        chk("lh_value", got_rdata, 32'hFFFF_8899);

        run_op(OP_SB, 32'h0040_0021, 32'h0000_00EE);
        chk("sb_merged", bmem[8], 32'h11EE_3344);

        run_op(OP_LW, 32'h0040_0022, 32'd0);
        chk("mis_lw_flag", {31'd0, got_mis}, 32'd1);
        chk("mis_lw_mem_A", mem_A, 32'h0040_0020);
        run_op(OP_SH, 32'h0040_0021, 32'hDEAD_BEEF);
        chk("mis_sh_flag", {31'd0, got_mis}, 32'd1);

        // Request held valid through an SH; the next one is taken as the SH responds.
        @(negedge CLK);
        r0 = resp_cnt; w0 = we_cnt;
        req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h0040_0012; req_wdata = 32'h1234_5678;
        @(posedge CLK);
        #1 req_op = OP_LHU; req_wdata = 32'd0;
        @(negedge CLK);
        chk("bp_busy_ready", {31'd0, req_ready}, 32'd0);
        chk("bp_busy_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge CLK);
        chk("bp_sh_resp", {31'd0, resp_valid}, 32'd1);
        chk("bp_sh_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_sh_we", {31'd0, mem_WE}, 32'd1);
        chk("bp_sh_wd", mem_WD, 32'h8899_5678);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        chk("bp_lhu_wait", {31'd0, resp_valid}, 32'd0);
        @(negedge CLK);
        chk("bp_lhu_resp", {31'd0, resp_valid}, 32'd1);
        chk("bp_lhu_data", resp_rdata, 32'h0000_5678);
        @(negedge CLK);
        chk("bp_resp_count", 32'(resp_cnt - r0), 32'd2);
        chk("bp_we_count", 32'(we_cnt - w0), 32'd1);
        last_a = 32'h0040_0010;

        // Reset lands while the SB read is outstanding.
        @(negedge CLK);
        r0 = resp_cnt; w0 = we_cnt;
        req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h0040_0011; req_wdata = 32'h0000_0055;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_we", {31'd0, mem_WE}, 32'd0);
        chk("rstmid_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        @(negedge CLK);
        chk("rstmid_resp_count", 32'(resp_cnt - r0), 32'd0);
        chk("rstmid_we_count", 32'(we_cnt - w0), 32'd0);
        chk("rstmid_mem", bmem[4], 32'h8899_5678);
        last_a = 32'd0;

        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom_range(0, 7)), 32'h0040_0000 | 32'($urandom_range(0, 1023)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
